// File: rtl/sad_fetch_pkg.sv
// Shared types, default geometry and lane-extraction helper for the SAD operand fetcher.
package sad_fetch_pkg;

    typedef enum logic [1:0] {IDLE, READ, WAIT, OUT} state_t;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_LANES  = 8;
    localparam int DEF_BEATS  = 2;
    localparam int BEAT_W     = $clog2(DEF_BEATS);
    localparam int SAD_W      = DEF_DATA_W + $clog2(DEF_LANES * DEF_BEATS);

    // Helper operates on a wide container so any (LANES, DATA_W) up to these limits fits.
    localparam int MAX_BUS_W  = 4096;
    localparam int MAX_LANE_W = 64;

    function automatic logic [MAX_LANE_W-1:0] lane_slice(input logic [MAX_BUS_W-1:0] bus,
                                                         input int i, input int w);
        return MAX_LANE_W'(bus >> (i * w));
    endfunction

endpackage

// File: rtl/sad_window_fetch_absdiff.sv
// Combinational sum of |A_i - B_i| over all lanes of one beat (unsigned compare-subtract).
module sad_lane_absdiff
    import sad_fetch_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LANES  = 8,
    parameter int SUM_W  = 36
) (
    input  logic [LANES*DATA_W-1:0] a,
    input  logic [LANES*DATA_W-1:0] b,
    output logic [SUM_W-1:0]        sum
);

    always_comb begin
        logic [DATA_W-1:0] ai;
        logic [DATA_W-1:0] bi;
        ai  = '0;
        bi  = '0;
        sum = '0;
        for (int i = 0; i < LANES; i++) begin
            ai  = DATA_W'(lane_slice(MAX_BUS_W'(a), i, DATA_W));
            bi  = DATA_W'(lane_slice(MAX_BUS_W'(b), i, DATA_W));
            sum = sum + SUM_W'((ai > bi) ? (ai - bi) : (bi - ai));
        end
    end

endmodule

// File: rtl/sad_window_fetch.sv
// SAD operand fetcher: window address computation plus BEATS-beat A/B stream with backpressure.
// Optional SAD accumulation is enabled by defining SAD_ACCUM_EN; otherwise sad_sum reads 0.
module sad_window_fetch
    import sad_fetch_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int LANES   = 8,
    parameter int BEATS   = 2,
    parameter int ADDR_W  = 16,
    parameter int MEM_LAT = 1
) (
    input  logic                                     Clk,
    input  logic                                     Reset,
    input  logic                                     req_valid,
    output logic                                     req_ready,
    input  logic [31:0]                              req_row,
    input  logic [31:0]                              req_col,
    input  logic [15:0]                              req_width,
    output logic                                     mem_rd_en,
    output logic [ADDR_W-1:0]                        mem_addr,
    input  logic [2*LANES*DATA_W-1:0]                mem_rd_data,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [LANES*DATA_W-1:0]                  out_a,
    output logic [LANES*DATA_W-1:0]                  out_b,
    output logic                                     out_last,
    output logic                                     addr_ovf,
    output logic [DATA_W+$clog2(LANES*BEATS)-1:0]    sad_sum
);

    localparam int BW       = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int SW       = DATA_W + $clog2(LANES * BEATS);
    localparam int LANE_BUS = LANES * DATA_W;

    state_t            state, state_nx;
    logic [BW-1:0]     beat;
    logic [LW-1:0]     wcnt;
    logic [31:0]       row_q, col_q;
    logic [15:0]       width_q;
    logic [63:0]       addr_full;
    logic              accept, last_beat, wait_done, capture;

    assign accept    = req_valid && req_ready;
    assign last_beat = (beat == BW'(BEATS - 1));
    assign wait_done = (wcnt == LW'(MEM_LAT - 1));
    assign capture   = (state == WAIT) && wait_done;

    // Full 48-bit row*width product, widened before the offset adds so overflow is observable.
    assign addr_full = (64'(48'(row_q) * 48'(width_q)) + 64'(col_q)
                        + 64'(beat) * 64'(LANES)) << 2;
    assign mem_addr  = mem_rd_en ? addr_full[ADDR_W-1:0] : '0;

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_valid) state_nx = READ;
            READ:    state_nx = WAIT;
            WAIT:    if (wait_done) state_nx = OUT;
            OUT:     if (out_ready) state_nx = last_beat ? IDLE : READ;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        mem_rd_en = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        case (state)
            IDLE:    req_ready = 1'b1;
            READ:    mem_rd_en = 1'b1;
            OUT: begin
                out_valid = 1'b1;
                out_last  = last_beat;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            beat     <= '0;
            wcnt     <= '0;
            addr_ovf <= 1'b0;
            out_a    <= '0;
            out_b    <= '0;
        end else begin
            if (accept) begin
                row_q    <= req_row;
                col_q    <= req_col;
                width_q  <= req_width;
                beat     <= '0;
                addr_ovf <= 1'b0;
            end
            if (state == READ) begin
                wcnt     <= '0;
                addr_ovf <= addr_ovf | (|addr_full[63:ADDR_W]);
            end
            if (state == WAIT) wcnt <= wcnt + 1'b1;
            if (capture) begin
                out_a <= mem_rd_data[LANE_BUS-1:0];
                out_b <= mem_rd_data[2*LANE_BUS-1:LANE_BUS];
            end
            if (state == OUT && out_ready && !last_beat) beat <= beat + 1'b1;
        end
    end

`ifdef SAD_ACCUM_EN
    logic [SW-1:0] beat_sad;
    logic [SW-1:0] sad_q;

    sad_lane_absdiff #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .SUM_W  (SW)
    ) u_absdiff (
        .a   (mem_rd_data[LANE_BUS-1:0]),
        .b   (mem_rd_data[2*LANE_BUS-1:LANE_BUS]),
        .sum (beat_sad)
    );

    always_ff @(posedge Clk) begin
        if (Reset || accept) sad_q <= '0;
        else if (capture)    sad_q <= sad_q + beat_sad;
    end

    assign sad_sum = sad_q;
`else
    assign sad_sum = '0;
`endif

endmodule

// File: tb/tb_sad_window_fetch.sv
// Directed bench for sad_window_fetch with a one-cycle-latency block-memory model.
module tb_sad_window_fetch;
    import sad_fetch_pkg::*;

    localparam int DW = 32;
    localparam int LN = 8;
    localparam int AW = 16;

    logic                 Clk = 1'b0;
    logic                 Reset = 1'b1;
    logic                 req_valid = 1'b0;
    logic                 req_ready;
    logic [31:0]          req_row = '0;
    logic [31:0]          req_col = '0;
    logic [15:0]          req_width = '0;
    logic                 mem_rd_en;
    logic [AW-1:0]        mem_addr;
    logic [2*LN*DW-1:0]   mem_rd_data = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [LN*DW-1:0]     out_a;
    logic [LN*DW-1:0]     out_b;
    logic                 out_last;
    logic                 addr_ovf;
    logic [SAD_W-1:0]     sad_sum;

    int pat = 0;
    int n_chk = 0;
    int n_err = 0;

    sad_window_fetch dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_row     (req_row),
        .req_col     (req_col),
        .req_width   (req_width),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_last    (out_last),
        .addr_ovf    (addr_ovf),
        .sad_sum     (sad_sum)
    );

    always #5 Clk = ~Clk;

    function automatic logic [DW-1:0] mem_word(input int p, input bit is_b,
                                               input logic [AW-1:0] a, input int i);
        if (p == 1) return is_b ? 32'd7 : 32'd10;
        if (p == 2) return is_b ? 32'd10 : 32'd7;
        return {(is_b ? 8'hBB : 8'hAA), a, 8'(i)};
    endfunction

    function automatic logic [2*LN*DW-1:0] mem_line(input int p, input logic [AW-1:0] a);
        logic [2*LN*DW-1:0] l;
        l = '0;
        for (int i = 0; i < LN; i++) begin
            l[i*DW +: DW]      = mem_word(p, 1'b0, a, i);
            l[(LN+i)*DW +: DW] = mem_word(p, 1'b1, a, i);
        end
        return l;
    endfunction

    // Pattern 0 lanes differ by exactly 0x11000000 (B above A); patterns 1/2 differ by 3.
    function automatic logic [SAD_W-1:0] exp_sad(input int p, input int beat_n);
`ifdef SAD_ACCUM_EN
        if (p == 0) return SAD_W'(36'h088000000 * 36'(beat_n + 1));
        return SAD_W'(24 * (beat_n + 1));
`else
        if (p < 0 || beat_n < 0) return '1;
        return '0;
`endif
    endfunction

    always @(posedge Clk) begin
        if (mem_rd_en) mem_rd_data <= mem_line(pat, mem_addr);
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic run_req(input logic [31:0] row, input logic [31:0] col, input logic [15:0] w,
                           input logic [AW-1:0] a0, input logic [AW-1:0] a1, input bit hold);
        logic [2*LN*DW-1:0] l0, l1;
        l0 = mem_line(pat, a0);
        l1 = mem_line(pat, a1);
        req_row = row; req_col = col; req_width = w; req_valid = 1'b1; out_ready = 1'b1;
        chk("idle_ready", 256'(req_ready), 256'(1));
        tick();
        if (!hold) req_valid = 1'b0;
        chk("read0_en", 256'(mem_rd_en), 256'(1));
        chk("read0_addr", 256'(mem_addr), 256'(a0));
        chk("busy_ready", 256'(req_ready), 256'(0));
        tick();
        chk("wait0_en", 256'(mem_rd_en), 256'(0));
        chk("wait0_valid", 256'(out_valid), 256'(0));
        tick();
        chk("out0_valid", 256'(out_valid), 256'(1));
        chk("out0_last", 256'(out_last), 256'(0));
        chk("out0_a", 256'(out_a), 256'(l0[LN*DW-1:0]));
        chk("out0_b", 256'(out_b), 256'(l0[2*LN*DW-1:LN*DW]));
        chk("out0_sad", 256'(sad_sum), 256'(exp_sad(pat, 0)));
        chk("out0_ready", 256'(req_ready), 256'(0));
        tick();
        chk("read1_en", 256'(mem_rd_en), 256'(1));
        chk("read1_addr", 256'(mem_addr), 256'(a1));
        tick();
        tick();
        chk("out1_valid", 256'(out_valid), 256'(1));
        chk("out1_last", 256'(out_last), 256'(1));
        chk("out1_a", 256'(out_a), 256'(l1[LN*DW-1:0]));
        chk("out1_b", 256'(out_b), 256'(l1[2*LN*DW-1:LN*DW]));
        chk("out1_sad", 256'(sad_sum), 256'(exp_sad(pat, 1)));
        tick();
        chk("done_ready", 256'(req_ready), 256'(1));
        chk("done_valid", 256'(out_valid), 256'(0));
        chk("done_sad_held", 256'(sad_sum), 256'(exp_sad(pat, 1)));
        req_valid = 1'b0;
    endtask

    initial begin
        logic [2*LN*DW-1:0] l0, l1;

        tick();
        tick();
        chk("rst_ready", 256'(req_ready), 256'(1));
        chk("rst_rd_en", 256'(mem_rd_en), 256'(0));
        chk("rst_addr", 256'(mem_addr), 256'(0));
        chk("rst_valid", 256'(out_valid), 256'(0));
        chk("rst_last", 256'(out_last), 256'(0));
        chk("rst_ovf", 256'(addr_ovf), 256'(0));
        chk("rst_sad", 256'(sad_sum), 256'(0));
        chk("rst_out_a", 256'(out_a), 256'(0));
        Reset = 1'b0;
        tick();

        // Basic two-beat request: (2*10+3)<<2 = 0x5C, then +8 lanes -> 0x7C.
        pat = 0;
        run_req(32'd2, 32'd3, 16'd10, 16'h005C, 16'h007C, 1'b0);
        chk("t1_no_ovf", 256'(addr_ovf), 256'(0));

        // Backpressure on beat 0: base 4 -> 0x10, beat 1 at 0x30.
        l0 = mem_line(0, 16'h0010);
        l1 = mem_line(0, 16'h0030);
        req_row = 32'd1; req_col = 32'd0; req_width = 16'd4; req_valid = 1'b1; out_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        chk("t2_addr0", 256'(mem_addr), 256'(16'h0010));
        tick();
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("t2_hold_valid", 256'(out_valid), 256'(1));
            chk("t2_hold_a", 256'(out_a), 256'(l0[LN*DW-1:0]));
            chk("t2_hold_b", 256'(out_b), 256'(l0[2*LN*DW-1:LN*DW]));
            chk("t2_hold_rd_en", 256'(mem_rd_en), 256'(0));
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("t2_read1_en", 256'(mem_rd_en), 256'(1));
        chk("t2_read1_addr", 256'(mem_addr), 256'(16'h0030));
        tick();
        tick();
        chk("t2_last", 256'(out_last), 256'(1));
        chk("t2_out1_a", 256'(out_a), 256'(l1[LN*DW-1:0]));
        tick();
        chk("t2_done_ready", 256'(req_ready), 256'(1));

        // Overflow: 0xFFFF*0xFFFF = 0xFFFE0001, <<2 truncated to 16 bits -> 0x0004, then 0x0024.
        run_req(32'h0000_FFFF, 32'd0, 16'hFFFF, 16'h0004, 16'h0024, 1'b0);
        chk("t3_ovf", 256'(addr_ovf), 256'(1));
        tick();
        tick();
        chk("t3_ovf_sticky", 256'(addr_ovf), 256'(1));

        // Reset during WAIT of beat 0; accept must first clear the overflow flag.
        req_row = 32'd0; req_col = 32'd2; req_width = 16'd0; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("t4_ovf_cleared", 256'(addr_ovf), 256'(0));
        chk("t4_addr", 256'(mem_addr), 256'(16'h0008));
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("t4_ready", 256'(req_ready), 256'(1));
        chk("t4_valid", 256'(out_valid), 256'(0));
        chk("t4_sad", 256'(sad_sum), 256'(0));
        chk("t4_out_a", 256'(out_a), 256'(0));
        tick();
        chk("t4_stay_idle", 256'(out_valid), 256'(0));
        chk("t4_no_last", 256'(out_last), 256'(0));

        // SAD patterns: A=10,B=7 then swapped; addresses 0x00 and 0x20.
        pat = 1;
        run_req(32'd0, 32'd0, 16'd0, 16'h0000, 16'h0020, 1'b0);
        pat = 2;
        run_req(32'd0, 32'd0, 16'd0, 16'h0000, 16'h0020, 1'b0);

        // Zero width with req_valid held through the whole request: 0x04 then 0x24.
        pat = 0;
        run_req(32'd5, 32'd1, 16'd0, 16'h0004, 16'h0024, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
